// File: rtl/reg_skid_buffer.sv
// Two-entry registered valid/ready slice: 1-cycle latency, full throughput while m_ready_i=1.
// A single skid entry absorbs the word in flight when downstream stalls; s_ready_o depends on registered state and en_i only.
module reg_skid_buffer #(
    parameter int                DATA_W  = 21,
    parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic [1:0]        level_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              push, pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            main_q  <= RST_VAL;
            skid_q  <= RST_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // push/pop already carry en_i through the handshake outputs, so a frozen slice holds.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = BUSY;
                    main_d  = s_data_i;
                end
            end
            BUSY: begin
                if (push && pop) begin
                    main_d = s_data_i;
                end else if (push) begin
                    state_d = FULL;
                    skid_d  = s_data_i;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        s_ready_o = en_i && (state_q != FULL);
        m_valid_o = en_i && (state_q != EMPTY);
        push      = s_valid_i && s_ready_o;
        pop       = m_valid_o && m_ready_i;
        m_data_o  = main_q;
        level_o   = state_q;
    end

endmodule

// File: tb/tb_reg_skid_buffer.sv
// Bench for reg_skid_buffer: queue-based reference model checked every cycle, plus directed literal checks.
module tb_reg_skid_buffer;

    localparam int DW = 21;
    localparam logic [DW-1:0] RV = '0;

    logic          clk = 1'b0;
    logic          rst, en, sv, mr;
    logic          s_ready, m_valid;
    logic [DW-1:0] sd, m_data;
    logic [1:0]    level;

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_on      = 1'b0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] mlast = RV;
    bit            do_pop, do_push;

    always #5 clk = ~clk;

    reg_skid_buffer #(.DATA_W(DW), .RST_VAL(RV)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .en_i     (en),
        .s_valid_i(sv),
        .s_ready_o(s_ready),
        .s_data_i (sd),
        .m_valid_o(m_valid),
        .m_ready_i(mr),
        .m_data_o (m_data),
        .level_o  (level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an ordered queue of at most two words; the output shows the oldest word,
    // or the most recently delivered word when nothing is held.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mlast = RV;
        end else if (en) begin
            do_pop  = (mq.size() > 0) && mr;
            do_push = sv && (mq.size() < 2);
            if (do_pop) mlast = mq.pop_front();
            if (do_push) mq.push_back(sd);
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_m_valid", {31'd0, m_valid}, {31'd0, en && (mq.size() > 0)});
            chk("model_s_ready", {31'd0, s_ready}, {31'd0, en && (mq.size() < 2)});
            chk("model_level", {30'd0, level}, mq.size());
            chk("model_m_data", {11'd0, m_data}, {11'd0, (mq.size() > 0) ? mq[0] : mlast});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; sv = 1'b1; sd = 21'h1ABCD; mr = 1'b0;
        tick();
        cmp_on = 1'b1;
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_level", {30'd0, level}, 32'd0);
        chk("rst_m_data", {11'd0, m_data}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        rst = 1'b0; sv = 1'b0;
        tick();

        // Streaming at one word per cycle
        mr = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            sv = 1'b1; sd = DW'(i);
            tick();
            chk("stream_data", {11'd0, m_data}, i);
            chk("stream_level", {30'd0, level}, 32'd1);
            chk("stream_s_ready", {31'd0, s_ready}, 32'd1);
        end
        sv = 1'b0;
        tick();
        chk("stream_drain_level", {30'd0, level}, 32'd0);
        chk("stream_drain_data", {11'd0, m_data}, 32'h10);

        // Backpressure fills the skid entry
        mr = 1'b0; sv = 1'b1; sd = 21'hA;
        tick();
        chk("bp_first_data", {11'd0, m_data}, 32'hA);
        sd = 21'hB;
        tick();
        chk("bp_full_level", {30'd0, level}, 32'd2);
        chk("bp_full_s_ready", {31'd0, s_ready}, 32'd0);
        chk("bp_full_data", {11'd0, m_data}, 32'hA);
        sv = 1'b0;
        tick();
        chk("bp_hold_data", {11'd0, m_data}, 32'hA);
        mr = 1'b1;
        tick();
        chk("bp_pop1_data", {11'd0, m_data}, 32'hB);
        chk("bp_pop1_s_ready", {31'd0, s_ready}, 32'd1);
        chk("bp_pop1_level", {30'd0, level}, 32'd1);
        tick();
        chk("bp_pop2_level", {30'd0, level}, 32'd0);

        // Simultaneous push and pop while busy
        mr = 1'b0; sv = 1'b1; sd = 21'h5;
        tick();
        chk("sim_main5", {11'd0, m_data}, 32'h5);
        sd = 21'h6; mr = 1'b1;
        tick();
        chk("sim_main6", {11'd0, m_data}, 32'h6);
        chk("sim_level", {30'd0, level}, 32'd1);
        sv = 1'b0;
        tick();

        // Freeze while full
        mr = 1'b0; sv = 1'b1; sd = 21'h3;
        tick();
        sd = 21'h4;
        tick();
        en = 1'b0; mr = 1'b1; sd = 21'h99;
        repeat (5) begin
            tick();
            chk("frz_m_valid", {31'd0, m_valid}, 32'd0);
            chk("frz_s_ready", {31'd0, s_ready}, 32'd0);
            chk("frz_level", {30'd0, level}, 32'd2);
            chk("frz_data", {11'd0, m_data}, 32'h3);
        end
        sv = 1'b0; en = 1'b1;
        #1;
        chk("frz_resume_valid", {31'd0, m_valid}, 32'd1);
        tick();
        chk("frz_out2", {11'd0, m_data}, 32'h4);
        chk("frz_out2_level", {30'd0, level}, 32'd1);
        tick();
        chk("frz_empty", {30'd0, level}, 32'd0);

        // Reset while full discards both entries
        mr = 1'b0; sv = 1'b1; sd = 21'h11;
        tick();
        sd = 21'h12;
        tick();
        chk("mrst_pre_level", {30'd0, level}, 32'd2);
        rst = 1'b1; sv = 1'b0; mr = 1'b1;
        tick();
        chk("mrst_level", {30'd0, level}, 32'd0);
        chk("mrst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("mrst_data", {11'd0, m_data}, 32'd0);
        rst = 1'b0; sv = 1'b1; sd = 21'h7;
        tick();
        chk("mrst_push7", {11'd0, m_data}, 32'h7);
        chk("mrst_push7_level", {30'd0, level}, 32'd1);
        sv = 1'b0;
        tick();
        chk("mrst_after_level", {30'd0, level}, 32'd0);
        chk("mrst_after_data", {11'd0, m_data}, 32'h7);

        // Mixed traffic, checked by the reference model only
        for (int i = 0; i < 300; i++) begin
            sv = ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 2) != 0);
            en = ($urandom_range(0, 9) != 0);
            sd = DW'($urandom);
            tick();
        end
        sv = 1'b0; en = 1'b1; mr = 1'b1;
        tick();
        tick();
        chk("final_drained", {30'd0, level}, 32'd0);

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
